// File: rtl/rand_pkg.sv
// Shared definitions for the range-reduced random value generator:
// FSM state type, LFSR byte width and the rejection-limit helper.
package rand_pkg;

    // Width of the raw pseudo-random byte supplied by the LFSR.
    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REDUCE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Largest multiple of range not exceeding 256. Bytes at or above it are
    // rejected so every residue is equally likely. 9 bits because the limit
    // equals 256 whenever range divides 256.
    function automatic logic [LFSR_W:0] calc_limit(input int range);
        int lim;
        lim = 256 - (256 % range);
        return lim[LFSR_W:0];
    endfunction

endpackage

// File: rtl/rand_range_gen.sv
// Converts LFSR bytes into uniform values in [0, RANGE-1]: rejection
// sampling against LIMIT, then repeated subtraction of RANGE. The LFSR is
// advanced only on the cycle a byte is consumed. Results are offered on a
// one-entry valid/ready buffer.
// Optional feature (macro RAND_RANGE_NO_REPEAT_EN): suppress a result equal
// to the previously transferred one and draw a fresh sample instead.
module rand_range_gen
    import rand_pkg::*;
#(
    parameter int RANGE = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] lfsr_i,
    output logic              lfsr_en_o,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [LFSR_W-1:0] value_o
);

    localparam logic [LFSR_W:0]   LIMIT   = calc_limit(RANGE);
    localparam logic [LFSR_W-1:0] RANGE_B = RANGE[LFSR_W-1:0];

    state_t            state;
    logic [LFSR_W-1:0] work;

`ifdef RAND_RANGE_NO_REPEAT_EN
    logic [LFSR_W-1:0] last_issued;
    logic              has_issued;
`endif

    // Advance the LFSR exactly when SAMPLE looks at the current byte.
    always_comb begin
        lfsr_en_o = (state == SAMPLE) && en_i;
    end

    // Sampling / reduction / output-hold sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            work    <= '0;
            value_o <= '0;
            valid_o <= 1'b0;
`ifdef RAND_RANGE_NO_REPEAT_EN
            last_issued <= '0;
            has_issued  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else if ({1'b0, lfsr_i} < LIMIT) begin
                        work  <= lfsr_i;
                        state <= REDUCE;
                    end
                    // Rejected bytes leave us in SAMPLE; the LFSR has
                    // already been advanced so the next byte is fresh.
                end
                REDUCE: begin
                    if (work >= RANGE_B) begin
                        work <= work - RANGE_B;
`ifdef RAND_RANGE_NO_REPEAT_EN
                    end else if (has_issued && (work == last_issued)) begin
                        // Repeat of the last delivered value: drop it.
                        state <= en_i ? SAMPLE : IDLE;
`endif
                    end else begin
                        value_o <= work;
                        valid_o <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= en_i ? SAMPLE : IDLE;
`ifdef RAND_RANGE_NO_REPEAT_EN
                        last_issued <= value_o;
                        has_issued  <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_range_gen.sv
// Self-checking bench for rand_range_gen. The bench plays the LFSR from a
// byte queue (popping when lfsr_en_o is seen high) and predicts each result
// from the arithmetic rules: first byte below LIMIT is used, the value is
// byte mod RANGE and valid appears byte/RANGE + 1 edges after sampling.
// Two instances: RANGE=10 (with rejection) and RANGE=16 (no rejection).
module tb_rand_range_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b, ready;
    logic [7:0] lfsr;
    logic       lfsr_en_a, valid_a, lfsr_en_b, valid_b;
    logic [7:0] value_a, value_b;

    rand_range_gen #(.RANGE(10)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .lfsr_i(lfsr),
        .lfsr_en_o(lfsr_en_a), .ready_i(ready), .valid_o(valid_a), .value_o(value_a)
    );

    rand_range_gen #(.RANGE(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .lfsr_i(lfsr),
        .lfsr_en_o(lfsr_en_b), .ready_i(ready), .valid_o(valid_b), .value_o(value_b)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    int         sel     = 0;      // which instance the byte source serves
    int         last_val = -1;    // last value delivered by dut_a
    logic [7:0] q[$];
    logic       s_en, s_valid;
    logic [7:0] s_value;

    task automatic present();
        lfsr = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    // One clock cycle: observe at negedge, pop a consumed byte at posedge,
    // then present the next byte shortly after the edge.
    task automatic tick();
        @(negedge clk);
        s_en    = (sel == 0) ? lfsr_en_a : lfsr_en_b;
        s_valid = (sel == 0) ? valid_a   : valid_b;
        s_value = (sel == 0) ? value_a   : value_b;
        @(posedge clk);
        if (s_en && q.size() > 0) void'(q.pop_front());
        #1;
        present();
    endtask

    task automatic set_en(input logic v);
        if (sel == 0) en_a = v; else en_b = v;
    endtask

    // Run one sample from the queued bytes and check enable pulses, latency
    // and value. exp_first is the tick on which the first byte is consumed.
    task automatic run_xact(input string name, input int range, input int exp_first);
        int limit, k, v, t, first_en, last_en, n_en, vt;
        logic [7:0] got;
        limit = 256 - (256 % range);
        k = -1;
        for (int i = 0; i < q.size(); i++) if (k < 0 && int'(q[i]) < limit) k = i;
        if (k < 0) begin
            vectors++; errors++;
            $display("FAIL %s: no acceptable byte queued", name);
            return;
        end
        v = int'(q[k]);
        present();
        t = 0; first_en = -1; last_en = -1; n_en = 0; vt = -1; got = 8'h00;
        while (vt < 0 && t < 300) begin
            tick();
            if (s_en) begin
                n_en++;
                if (first_en < 0) first_en = t;
                last_en = t;
            end
            if (s_valid) begin vt = t; got = s_value; end
            t++;
        end
        vectors++;
        if (vt < 0) begin errors++; $display("FAIL %s_timeout: valid never rose", name); end
        vectors++;
        if (first_en !== exp_first) begin
            errors++; $display("FAIL %s_first_en: got tick %0d want %0d", name, first_en, exp_first);
        end
        vectors++;
        if (n_en !== k + 1 || last_en - first_en !== k) begin
            errors++; $display("FAIL %s_en_pulses: got %0d want %0d consecutive", name, n_en, k + 1);
        end
        vectors++;
        if (vt !== last_en + v / range + 2) begin
            errors++; $display("FAIL %s_latency: valid at tick %0d want %0d (byte %0d)", name, vt, last_en + v / range + 2, v);
        end
        vectors++;
        if (int'(got) !== v % range) begin
            errors++; $display("FAIL %s_value: got %0d want %0d", name, got, v % range);
        end
        if (sel == 0) last_val = v % range;
        $display("xact %s: byte %0d -> value %0d, valid at tick %0d", name, v, got, vt);
    endtask

    // Accept the held result; en_next chooses where the block goes next.
    task automatic transfer(input string name, input logic en_next);
        set_en(en_next);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors++;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL %s_transfer: valid %0b want 1", name, s_valid); end
    endtask

    function automatic logic [7:0] pick_byte();
        int v;
        do v = int'($urandom_range(0, 249)); while (v % 10 == last_val);
        return v[7:0];
    endfunction

    task automatic test_reset();
        sel = 0; rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0; ready = 1'b0; lfsr = 8'd5;
        repeat (3) begin
            tick();
            vectors++;
            if (s_valid !== 1'b0 || s_value !== 8'd0 || s_en !== 1'b0) begin
                errors++; $display("FAIL reset_hold: valid %0b value %0d lfsr_en %0b want 0/0/0", s_valid, s_value, s_en);
            end
        end
        en_a = 1'b0; rst_n = 1'b1;
        // Reset in the middle of reducing 200: no result may appear later.
        q.delete(); q.push_back(8'd200); present(); en_a = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0; en_a = 1'b0;
        #1;
        vectors++;
        if (valid_a !== 1'b0 || lfsr_en_a !== 1'b0) begin
            errors++; $display("FAIL reset_mid_reduce: valid %0b lfsr_en %0b want 0/0", valid_a, lfsr_en_a);
        end
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            vectors++;
            if (s_valid !== 1'b0 || s_en !== 1'b0) begin
                errors++; $display("FAIL reset_no_late_result: valid %0b lfsr_en %0b want 0/0", s_valid, s_en);
            end
        end
        // Reset while holding a result must drop valid without a clock edge.
        q.delete(); q.push_back(8'd3); present(); en_a = 1'b1;
        repeat (3) tick();
        vectors++;
        if (valid_a !== 1'b1) begin errors++; $display("FAIL reset_pre_hold: valid %0b want 1", valid_a); end
        en_a = 1'b0; rst_n = 1'b0;
        #1;
        vectors++;
        if (valid_a !== 1'b0 || value_a !== 8'd0) begin
            errors++; $display("FAIL reset_async: valid %0b value %0d want 0/0", valid_a, value_a);
        end
        tick(); rst_n = 1'b1; q.delete(); present();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        sel = 0; q.push_back(8'd37); en_a = 1'b1;
        run_xact("basic", 10, 1);
        transfer("basic", 1'b0);
    endtask

    task automatic test_reject();
        sel = 0; q.push_back(8'd252); q.push_back(8'd5); en_a = 1'b1;
        run_xact("reject", 10, 1);
        transfer("reject", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] v0;
        sel = 0; q.push_back(pick_byte()); en_a = 1'b1;
        run_xact("bp", 10, 1);
        v0 = 8'(last_val);
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (s_valid !== 1'b1 || s_value !== v0 || s_en !== 1'b0) begin
                errors++; $display("FAIL bp_hold: valid %0b value %0d lfsr_en %0b want 1/%0d/0", s_valid, s_value, s_en, v0);
            end
        end
        q.push_back(pick_byte());
        transfer("bp", 1'b1);
        run_xact("bp_next", 10, 0);
        transfer("bp_next", 1'b0);
    endtask

    task automatic test_en_gating();
        int v, t, vt;
        sel = 0; v = 90 + ((last_val + 3) % 10);
        q.push_back(8'(v)); present(); en_a = 1'b1;
        tick();
        tick();
        vectors++;
        if (s_en !== 1'b1) begin errors++; $display("FAIL gate_sample: lfsr_en %0b want 1", s_en); end
        en_a = 1'b0;
        t = 1; vt = -1;
        while (vt < 0 && t < 40) begin
            tick();
            if (s_valid) vt = t;
            t++;
        end
        vectors++;
        if (vt !== v / 10 + 2 || int'(s_value) !== v % 10) begin
            errors++; $display("FAIL gate_result: tick %0d value %0d want %0d/%0d", vt, s_value, v / 10 + 2, v % 10);
        end
        last_val = v % 10;
        transfer("gate", 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (s_en !== 1'b0 || s_valid !== 1'b0) begin
                errors++; $display("FAIL gate_idle: lfsr_en %0b valid %0b want 0/0", s_en, s_valid);
            end
        end
        sel = 1; q.push_back(8'd255); en_b = 1'b1;
        run_xact("range16", 16, 1);
        transfer("range16", 1'b0);
        sel = 0;
        $display("test_en_gating done: byte %0d", v);
    endtask

    task automatic test_random();
        int r;
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 2));
            for (int j = 0; j < r; j++) q.push_back(8'($urandom_range(250, 255)));
            q.push_back(pick_byte());
            en_a = 1'b1;
            run_xact("random", 10, (i == 0) ? 1 : 0);
            repeat ($urandom_range(0, 3)) tick();
            transfer("random", i < 7);
        end
    endtask

    task automatic test_macro();
        int t, n_en, exp_en, exp_val;
        logic seen;
        sel = 0; rst_n = 1'b0; en_a = 1'b0; q.delete();
        tick(); rst_n = 1'b1;
        q.push_back(8'd37); en_a = 1'b1;
        run_xact("macro_first", 10, 1);
        q.push_back(8'd17); q.push_back(8'd3);
        transfer("macro_first", 1'b1);
`ifdef RAND_RANGE_NO_REPEAT_EN
        exp_en = 2; exp_val = 3;
`else
        exp_en = 1; exp_val = 7;
`endif
        t = 0; n_en = 0; seen = 1'b0;
        while (!seen && t < 60) begin
            tick();
            if (s_en) n_en++;
            seen = s_valid;
            t++;
        end
        vectors++;
        if (!seen || int'(s_value) !== exp_val || n_en !== exp_en) begin
            errors++; $display("FAIL macro_repeat: valid %0b value %0d bytes %0d want 1/%0d/%0d", seen, s_value, n_en, exp_val, exp_en);
        end
        $display("xact macro_repeat: value %0d after %0d bytes", s_value, n_en);
        transfer("macro_repeat", 1'b0);
        q.delete(); present();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_backpressure();
        test_en_gating();
        test_random();
        test_macro();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
